program_loader: RTL and testbench

Writer side of the instruction store. Receives a byte stream from the UART receiver and assembles little-endian 16-bit instruction words. Writes each word into program memory at consecutive addresses starting at 0, and holds the CPU in reset until loading completes. Loading terminates when the HALT word (16'h0000, opcode 00000) has been written.

---
 rtl/program_loader_pkg.sv | 27 ++
 rtl/program_loader_assembler.sv | 55 +++++
 rtl/program_loader.sv | 138 +++++++++++++
 tb/tb_program_loader.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared types and constants for the program loader.
// Optional build macro: PROGRAM_LOADER_CHECKSUM_EN.
package program_loader_pkg;

    typedef enum logic [2:0] {
        LO,
        HI,
        CHECK,
        DONE,
        ERROR
    } state_t;

    localparam int unsigned OPCODE_W  = 5;
    localparam int unsigned OPERAND_W = 11;
    localparam int unsigned WORD_W    = OPCODE_W + OPERAND_W;

    localparam logic [WORD_W-1:0]   HALT_WORD   = '0;
    localparam logic [OPCODE_W-1:0] OPCODE_HALT = '0;

    // First byte received on the wire is the low byte of the instruction.
    localparam bit FIRST_BYTE_LOW = 1'b1;

    function automatic logic is_halt(input logic [WORD_W-1:0] word);
        return (word[WORD_W-1 -: OPCODE_W] == OPCODE_HALT) && (word == HALT_WORD);
    endfunction

endpackage

// File: rtl/program_loader_assembler.sv
// Byte latch, 16-bit word assembly and optional running checksum.
// Optional build macro: PROGRAM_LOADER_CHECKSUM_EN.
module program_loader_assembler
    import program_loader_pkg::*;
#(
    parameter int NBITS_B = 8,
    parameter int NBITS_D = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NBITS_B-1:0] rx_data,
    input  logic               take_lo,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    input  logic               take_hi,
    output logic               sum_ok,
`endif
    output logic [NBITS_D-1:0] word
);

    logic [NBITS_B-1:0] lo;

    always_ff @(posedge clk) begin
        if (reset) begin
            lo <= '0;
        end else if (take_lo) begin
            lo <= rx_data;
        end
    end

    always_comb begin
        if (FIRST_BYTE_LOW) begin
            word = NBITS_D'({rx_data, lo});
        end else begin
            word = NBITS_D'({lo, rx_data});
        end
    end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [NBITS_B-1:0] sum;

    always_ff @(posedge clk) begin
        if (reset) begin
            sum <= '0;
        end else if (take_lo || take_hi) begin
            sum <= sum + rx_data;
        end
    end

    // The check byte itself closes the sum to zero.
    always_comb begin
        sum_ok = (NBITS_B'(sum + rx_data) == '0);
    end
`endif

endmodule

// File: rtl/program_loader.sv
// Loads a little-endian byte stream into program memory and holds the CPU in reset until done.
// Optional build macro: PROGRAM_LOADER_CHECKSUM_EN.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int NBITS_O = 11,
    parameter int NBITS_D = 16,
    parameter int NBITS_B = 8,
    parameter int CELDAS  = 512
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NBITS_B-1:0] i_rx_data,
    input  logic               i_rx_valid,
    output logic               o_wr_en,
    output logic [NBITS_O-1:0] o_wr_addr,
    output logic [NBITS_D-1:0] o_wr_data,
    output logic               o_cpu_reset,
    output logic               o_done,
    output logic               o_error,
    output logic [NBITS_O:0]   o_word_count
);

    localparam logic [NBITS_O-1:0] LAST_ADDR = NBITS_O'(CELDAS - 1);

    state_t             state;
    state_t             next_state;
    logic [NBITS_O-1:0] addr;
    logic [NBITS_D-1:0] word;
    logic               take_lo;
    logic               write;
    logic               done_d;
    logic               error_d;

    assign take_lo = (state == LO) && i_rx_valid;
    assign write   = (state == HI) && i_rx_valid;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic sum_ok;

    program_loader_assembler #(
        .NBITS_B (NBITS_B),
        .NBITS_D (NBITS_D)
    ) u_assembler (
        .clk     (i_clk),
        .reset   (i_reset),
        .rx_data (i_rx_data),
        .take_lo (take_lo),
        .take_hi (write),
        .sum_ok  (sum_ok),
        .word    (word)
    );
`else
    program_loader_assembler #(
        .NBITS_B (NBITS_B),
        .NBITS_D (NBITS_D)
    ) u_assembler (
        .clk     (i_clk),
        .reset   (i_reset),
        .rx_data (i_rx_data),
        .take_lo (take_lo),
        .word    (word)
    );
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= LO;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            LO: begin
                if (i_rx_valid) begin
                    next_state = HI;
                end
            end
            HI: begin
                if (i_rx_valid) begin
                    if (is_halt(word)) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        next_state = CHECK;
`else
                        next_state = DONE;
`endif
                    end else if (addr == LAST_ADDR) begin
                        next_state = ERROR;
                    end else begin
                        next_state = LO;
                    end
                end
            end
            CHECK: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                if (i_rx_valid) begin
                    next_state = sum_ok ? DONE : ERROR;
                end
`endif
            end
            DONE:    next_state = DONE;
            ERROR:   next_state = ERROR;
            default: next_state = LO;
        endcase
    end

    // Leaving HI the flags wait one extra cycle so the final write lands first.
    assign done_d  = (next_state == DONE)  && (state != HI);
    assign error_d = (next_state == ERROR) && (state != HI);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_wr_en      <= 1'b0;
            o_wr_addr    <= '0;
            o_wr_data    <= '0;
            o_cpu_reset  <= 1'b1;
            o_done       <= 1'b0;
            o_error      <= 1'b0;
            o_word_count <= '0;
            addr         <= '0;
        end else begin
            o_wr_en     <= write;
            o_done      <= done_d;
            o_error     <= error_d;
            o_cpu_reset <= !done_d;
            if (write) begin
                o_wr_addr    <= addr;
                o_wr_data    <= word;
                addr         <= addr + 1'b1;
                o_word_count <= o_word_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader (default and CELDAS=4 instances).
// Optional build macro: PROGRAM_LOADER_CHECKSUM_EN.
module tb_program_loader;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;

    logic        wr_en,  wr_en4;
    logic [10:0] wr_addr, wr_addr4;
    logic [15:0] wr_data, wr_data4;
    logic        cpu_reset, cpu_reset4;
    logic        done, done4;
    logic        error, error4;
    logic [11:0] word_count, word_count4;

    int total = 0;
    int bad   = 0;

    logic [10:0] log_addr[$];
    logic [15:0] log_data[$];
    logic [10:0] log_addr4[$];
    logic [15:0] log_data4[$];

    program_loader dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_rx_data    (rx_data),
        .i_rx_valid   (rx_valid),
        .o_wr_en      (wr_en),
        .o_wr_addr    (wr_addr),
        .o_wr_data    (wr_data),
        .o_cpu_reset  (cpu_reset),
        .o_done       (done),
        .o_error      (error),
        .o_word_count (word_count)
    );

    program_loader #(
        .CELDAS (4)
    ) dut4 (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_rx_data    (rx_data),
        .i_rx_valid   (rx_valid),
        .o_wr_en      (wr_en4),
        .o_wr_addr    (wr_addr4),
        .o_wr_data    (wr_data4),
        .o_cpu_reset  (cpu_reset4),
        .o_done       (done4),
        .o_error      (error4),
        .o_word_count (word_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en) begin
            log_addr.push_back(wr_addr);
            log_data.push_back(wr_data);
        end
        if (wr_en4) begin
            log_addr4.push_back(wr_addr4);
            log_data4.push_back(wr_data4);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle strobe; returns 1 time unit after the sampling edge.
    task automatic drive(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        log_addr.delete();
        log_data.delete();
        log_addr4.delete();
        log_data4.delete();
    endtask

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        idle(2);

        // Reset state
        do_reset();
        check("rst_wr_en",   32'(wr_en),      32'd0);
        check("rst_wr_addr", 32'(wr_addr),    32'd0);
        check("rst_wr_data", 32'(wr_data),    32'd0);
        check("rst_cpu_rst", 32'(cpu_reset),  32'd1);
        check("rst_done",    32'(done),       32'd0);
        check("rst_error",   32'(error),      32'd0);
        check("rst_count",   32'(word_count), 32'd0);

        // Basic two-word program with spaced bytes
        drive(8'h01); idle(1);
        drive(8'h10); idle(1);
        drive(8'h00); idle(1);
        drive(8'h00);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        check("t1_wr_pulse", 32'(wr_en),     32'd1);
        check("t1_pending",  32'(done),      32'd0);
        idle(1);
        check("t1_check_rst", 32'(cpu_reset), 32'd1);
        drive(8'hEF);
        check("t1_done",     32'(done),      32'd1);
        check("t1_cpu_rel",  32'(cpu_reset), 32'd0);
`else
        check("t1_wr_pulse", 32'(wr_en),     32'd1);
        check("t1_done_n1",  32'(done),      32'd0);
        check("t1_cpu_n1",   32'(cpu_reset), 32'd1);
        idle(1);
        check("t1_wr_off",   32'(wr_en),     32'd0);
        check("t1_done",     32'(done),      32'd1);
        check("t1_cpu_rel",  32'(cpu_reset), 32'd0);
`endif
        check("t1_error",    32'(error),       32'd0);
        check("t1_count",    32'(word_count),  32'd2);
        check("t1_nwrites",  32'(log_addr.size()), 32'd2);
        check("t1_addr0",    32'(log_addr[0]), 32'd0);
        check("t1_data0",    32'(log_data[0]), 32'h1001);
        check("t1_addr1",    32'(log_addr[1]), 32'd1);
        check("t1_data1",    32'(log_data[1]), 32'h0000);

        // Bytes after DONE are ignored
        drive(8'h12);
        drive(8'h34);
        idle(2);
        check("t5_nwrites",  32'(log_addr.size()), 32'd2);
        check("t5_done",     32'(done),       32'd1);
        check("t5_count",    32'(word_count), 32'd2);

        // Back-to-back strobes, three words
        do_reset();
        drive(8'h02); drive(8'h28);
        drive(8'h03); drive(8'h18);
        drive(8'h00); drive(8'h00);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        drive(8'hBB);
`endif
        idle(3);
        check("t2_nwrites",  32'(log_addr.size()), 32'd3);
        check("t2_addr0",    32'(log_addr[0]), 32'd0);
        check("t2_data0",    32'(log_data[0]), 32'h2802);
        check("t2_addr1",    32'(log_addr[1]), 32'd1);
        check("t2_data1",    32'(log_data[1]), 32'h1803);
        check("t2_addr2",    32'(log_addr[2]), 32'd2);
        check("t2_data2",    32'(log_data[2]), 32'h0000);
        check("t2_done",     32'(done),        32'd1);
        check("t2_count",    32'(word_count),  32'd3);

        // Reset mid-word discards the pending low byte
        do_reset();
        drive(8'h55);
        do_reset();
        drive(8'h01); drive(8'h10);
        drive(8'h00); drive(8'h00);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        drive(8'hEF);
`endif
        idle(3);
        check("t3_nwrites",  32'(log_addr.size()), 32'd2);
        check("t3_addr0",    32'(log_addr[0]), 32'd0);
        check("t3_data0",    32'(log_data[0]), 32'h1001);
        check("t3_done",     32'(done),        32'd1);

        // Overflow on the 4-deep instance
        do_reset();
        drive(8'h11); idle(1); drive(8'h22); idle(1);
        drive(8'h33); idle(1); drive(8'h44); idle(1);
        drive(8'h55); idle(1); drive(8'h66); idle(1);
        drive(8'h77); idle(1); drive(8'h88);
        check("t4_err_n1",   32'(error4),      32'd0);
        check("t4_wr_pulse", 32'(wr_en4),      32'd1);
        idle(1);
        check("t4_error",    32'(error4),      32'd1);
        check("t4_cpu_rst",  32'(cpu_reset4),  32'd1);
        check("t4_done",     32'(done4),       32'd0);
        check("t4_count",    32'(word_count4), 32'd4);
        check("t4_nwrites",  32'(log_addr4.size()), 32'd4);
        check("t4_addr3",    32'(log_addr4[3]), 32'd3);
        check("t4_data0",    32'(log_data4[0]), 32'h2211);
        check("t4_data3",    32'(log_data4[3]), 32'h8877);
        drive(8'h00); drive(8'h00);
        idle(2);
        check("t4_no_more",  32'(log_addr4.size()), 32'd4);
        check("t4_err_hold", 32'(error4),      32'd1);
        check("t4_done_n",   32'(done4),       32'd0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        // Bad checksum byte
        do_reset();
        drive(8'h01); drive(8'h10);
        drive(8'h00); drive(8'h00);
        idle(1);
        drive(8'hEE);
        check("t6_error",    32'(error),     32'd1);
        check("t6_done",     32'(done),      32'd0);
        check("t6_cpu_rst",  32'(cpu_reset), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
